// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, pattern mode encodings and colour constants
package vga_pkg;

  localparam int VGA_H_VISIBLE = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_PULSE   = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_VISIBLE = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_PULSE   = 2;
  localparam int VGA_V_BACK    = 33;

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_BARS  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_GRAD  = 2'd3;

  localparam logic [5:0] COLOR_RED   = 6'b110000;
  localparam logic [5:0] COLOR_GREEN = 6'b001100;
  localparam logic [5:0] COLOR_BLUE  = 6'b000011;
  localparam logic [5:0] COLOR_WHITE = 6'b111111;

  function automatic int axis_total(input int visible, input int front, input int pulse,
                                    input int back);
    return visible + front + pulse + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: wrapping counter plus visible/sync region decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = VGA_H_VISIBLE,
  parameter int FRONT   = VGA_H_FRONT,
  parameter int PULSE   = VGA_H_PULSE,
  parameter int BACK    = VGA_H_BACK,
  parameter int W       = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         vis,
  output logic         sync_act
);

  localparam int TOTAL = axis_total(VISIBLE, FRONT, PULSE, BACK);
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS_END = W'(VISIBLE);
  localparam logic [W-1:0] SYNC_LO = W'(VISIBLE + FRONT);
  localparam logic [W-1:0] SYNC_HI = W'(VISIBLE + FRONT + PULSE);

  if (TOTAL >= (1 << W)) begin : g_width_check
    $error("vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= wrap ? '0 : cnt + 1'b1;
    end
  end

  // wrap flags the terminal count; the caller qualifies it with its own enable
  assign wrap     = (cnt == LAST);
  assign vis      = (cnt < VIS_END);
  assign sync_act = (cnt >= SYNC_LO) && (cnt < SYNC_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA sync generator with four selectable test patterns
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE   = VGA_H_VISIBLE,
  parameter int H_FRONT     = VGA_H_FRONT,
  parameter int H_PULSE     = VGA_H_PULSE,
  parameter int H_BACK      = VGA_H_BACK,
  parameter int V_VISIBLE   = VGA_V_VISIBLE,
  parameter int V_FRONT     = VGA_V_FRONT,
  parameter int V_PULSE     = VGA_V_PULSE,
  parameter int V_BACK      = VGA_V_BACK,
  parameter int SYNC_ACTIVE = 0,
  parameter int CW          = 2,
  parameter int CHECK_LOG2  = 5,
  parameter int CNT_W       = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  input  logic [1:0]        mode,
  input  logic [3*CW-1:0]   solid_rgb,
  output logic [CW-1:0]     vga_r,
  output logic [CW-1:0]     vga_g,
  output logic [CW-1:0]     vga_b,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [CNT_W-1:0]  hpos,
  output logic [CNT_W-1:0]  vpos,
  output logic              line_start,
  output logic              frame_start
);

  localparam logic SYNC_LVL = SYNC_ACTIVE[0];
  localparam int   H_LOG2   = $clog2(H_VISIBLE);

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_wrap, v_wrap, h_vis, v_vis, h_sync, v_sync;
  logic             vis, frame_end;
  logic [1:0]       mode_q;
  logic [7:0]       frame_cnt;
  logic [2:0]       bar_idx;
  logic             chk_on;
  logic [3*CW-1:0]  pat;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .PULSE(H_PULSE), .BACK(H_BACK), .W(CNT_W)
  ) u_h (
    .clk(clk), .rst(rst), .inc(pix_ce),
    .cnt(h_cnt), .wrap(h_wrap), .vis(h_vis), .sync_act(h_sync)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .PULSE(V_PULSE), .BACK(V_BACK), .W(CNT_W)
  ) u_v (
    .clk(clk), .rst(rst), .inc(pix_ce & h_wrap),
    .cnt(v_cnt), .wrap(v_wrap), .vis(v_vis), .sync_act(v_sync)
  );

  assign vis       = h_vis & v_vis;
  assign frame_end = pix_ce & h_wrap & v_wrap;

  // mode only changes on the last pixel of a frame so a frame is never drawn in two modes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_SOLID;
      frame_cnt <= 8'd0;
    end else if (frame_end) begin
      mode_q    <= mode;
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  if ((1 << H_LOG2) == H_VISIBLE) begin : g_bars_pow2
    assign bar_idx = 3'({h_cnt, 3'b000} >> H_LOG2);
  end else begin : g_bars_cmp
    // bar k starts at ceil(k*H_VISIBLE/8), matching floor(x*8/H_VISIBLE)
    always_comb begin
      bar_idx = 3'd0;
      for (int k = 1; k < 8; k++) begin
        if (h_cnt >= CNT_W'((k * H_VISIBLE + 7) / 8)) bar_idx = 3'(k);
      end
    end
  end

  assign chk_on = h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2];

  always_comb begin
    pat = '0;
    case (mode_q)
      MODE_SOLID: pat = solid_rgb;
      MODE_BARS:  pat = {{CW{bar_idx[2]}}, {CW{bar_idx[1]}}, {CW{bar_idx[0]}}};
      MODE_CHECK: pat = {(3*CW){chk_on}};
      MODE_GRAD:  pat = {h_cnt[CW+5:6], v_cnt[CW+5:6], frame_cnt[7:8-CW]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync                 <= ~SYNC_LVL;
      vsync                 <= ~SYNC_LVL;
      de                    <= 1'b0;
      {vga_r, vga_g, vga_b} <= '0;
      hpos                  <= '0;
      vpos                  <= '0;
      line_start            <= 1'b0;
      frame_start           <= 1'b0;
    end else if (pix_ce) begin
      hsync                 <= h_sync ? SYNC_LVL : ~SYNC_LVL;
      vsync                 <= v_sync ? SYNC_LVL : ~SYNC_LVL;
      de                    <= vis;
      {vga_r, vga_g, vga_b} <= vis ? pat : '0;
      hpos                  <= h_cnt;
      vpos                  <= v_cnt;
      line_start            <= (h_cnt == '0);
      frame_start           <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA sync and test-pattern generator; successor to the fixed 640x480 solid-colour VGA block.
- Generates hsync/vsync from configurable timing parameters, exposes pixel coordinates and strobes, and drives RGB from one of four selectable pattern modes.
- Adds configurable sync polarity, pixel clock-enable, and frame-aligned mode switching.
- Sits between the demo top level and the TinyVGA output pins.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch in pixels
- H_PULSE, 96, hsync pulse width in pixels
- H_BACK, 48, horizontal back porch in pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch in lines
- V_PULSE, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch in lines
- SYNC_ACTIVE, 0, asserted level of hsync/vsync
- CW, 2, bits per colour channel
- CHECK_LOG2, 5, log2 of checkerboard square size in pixels
- CNT_W, 11, width of the h/v counters (must hold H_TOTAL-1 and V_TOTAL-1)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- pix_ce  in  1  pixel clock-enable; counters and outputs advance only when high
- mode  in  2  pattern select: 0 solid, 1 bars, 2 checker, 3 gradient
- solid_rgb  in  3*CW  colour for mode 0, packed {r,g,b}
- vga_r  out  CW  red
- vga_g  out  CW  green
- vga_b  out  CW  blue
- hsync  out  1  horizontal sync
- vsync  out  1  vertical sync
- de  out  1  display enable (visible pixel)
- hpos  out  CNT_W  current h counter
- vpos  out  CNT_W  current v counter
- line_start  out  1  one-cycle strobe at h=0
- frame_start  out  1  one-cycle strobe at h=0,v=0

Behaviour:
- Timing totals: H_TOTAL = sum of the four H parameters (800 at defaults); V_TOTAL = sum of the four V parameters (525 at defaults).
- Reset is asynchronous, active-high.
  - h_cnt, v_cnt, frame counter and latched mode reset to 0.
  - hsync and vsync reset to ~SYNC_ACTIVE; de, line_start, frame_start and RGB reset to 0; hpos and vpos reset to 0.
  - Reset asserted mid-line takes effect immediately. The first pixel after deassertion is (0,0).
- Counters (advance only when pix_ce=1):
  - h_cnt wraps at H_TOTAL-1 to 0.
  - v_cnt increments only when h_cnt wraps, and itself wraps at V_TOTAL-1 to 0.
  - When pix_ce=0, every register holds, and the strobes hold their previous value.
- Decode from (h_cnt, v_cnt):
  - vis = h<H_VISIBLE && v<V_VISIBLE.
  - hs_act = H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_PULSE.
  - vs_act uses the same formula with the V parameters; it is evaluated per line, independent of h.
- Output pipeline:
  - All outputs are registered, with a latency of exactly one enabled cycle from the counter value.
  - hpos and vpos are registered copies of the counters, aligned with RGB and the syncs.
  - hsync = hs_act ? SYNC_ACTIVE : ~SYNC_ACTIVE; vsync follows the same rule.
  - de = vis. RGB is forced to 0 whenever vis=0.
- Mode latch:
  - mode is sampled into mode_q only on the enabled cycle where h=H_TOTAL-1 and v=V_TOTAL-1.
  - A mode change mid-frame never tears the image.
  - On the same cycle, frame_cnt (8 bits) increments and wraps 255 to 0.
- Patterns (x=h_cnt, y=v_cnt; each channel CW bits):
  - 0 (solid): solid_rgb.
  - 1 (bars): idx = bar number from x*8/H_VISIBLE, computed as (x*8)>>log2 only when H_VISIBLE is a power of two; otherwise a compare chain on multiples of H_VISIBLE/8. RGB = {idx[2] x CW, idx[1] x CW, idx[0] x CW}.
  - 2 (checker): white (all ones) when x[CHECK_LOG2]^y[CHECK_LOG2] is 1, else black.
  - 3 (gradient): r = x[CW+5:6]; g = y[CW+5:6]; b = frame_cnt[7:8-CW].
- Strobes: line_start = registered (h==0); frame_start = registered (h==0 && v==0). Both are gated by pix_ce.
- Widths: all comparisons are done at CNT_W bits. H_TOTAL and V_TOTAL must be < 2^CNT_W; an elaboration-time check enforces this.

Decomposition:
- Shared package vga_pkg holds:
  - the 640x480@60 timing constants;
  - mode encodings MODE_SOLID, MODE_BARS, MODE_CHECK, MODE_GRAD;
  - the 6-bit colour constants previously hard-coded (red 110000, green 001100, blue 000011, white 111111).
- One sub-module, vga_axis_counter, instantiated twice (h and v):
  - parameters VISIBLE, FRONT, PULSE, BACK, W;
  - inputs clk, rst, inc;
  - outputs cnt, wrap, vis, sync_act.
- The pattern mux stays in the top module.

Test Plan:
- Reset then 800*525 cycles, defaults, pix_ce=1: hsync low for exactly 96 cycles, starting 656 cycles after line_start; vsync low for 2 lines starting at line 490; frame_start period is 420000 cycles.
- mode=0, solid_rgb=6'b110000: vga_r=2'b11 and g=b=0 while de=1; RGB=0 in every blanking cycle, including h=640..799.
- mode=2, CHECK_LOG2=5: pixel (0,0) black, (32,0) white, (32,32) black, (639,479) white.
- Change mode from 0 to 3 at v=100: output stays mode 0 until frame_start, then b = frame_cnt[7:6] and increments every 64 frames.
- pix_ce toggling 1,0,1,0: the full frame takes 840000 clk cycles; outputs hold when pix_ce=0; strobes last exactly one enabled cycle.
- Assert rst at h=300,v=200 for 3 cycles: outputs go to reset values immediately and asynchronously; the first enabled cycle after release produces hpos=0, vpos=0, line_start=1, frame_start=1. Repeat with SYNC_ACTIVE=1: syncs idle low during reset.
